multi_key_decoder: RTL

- Parametrised successor to the single-key decoder. It watches the PS/2 scan-code stream (keyCode/make/brakee) for NUM_KEYS configurable key codes at once.
- Per key it produces:
  - a held level
  - a rising-edge pulse and a falling-edge pulse
  - a toggle latch
  - an optional typematic auto-repeat pulse train
- Sits between the keyboard interface and the game control logic (paddle movement, menu keys).

---
 rtl/multi_key_decoder_if.sv | 9 +
 rtl/multi_key_decoder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/multi_key_decoder_if.sv
// Keyboard scan-code stream as seen by key decoders: code plus make/break strobes.
interface multi_key_decoder_if;
  logic [8:0] keyCode;
  logic       make;
  logic       brakee;

  modport master (output keyCode, make, brakee);
  modport slave  (input  keyCode, make, brakee);
endinterface

// File: rtl/multi_key_decoder.sv
// Decodes NUM_KEYS configurable PS/2 keys into level, edge, toggle and
// typematic auto-repeat outputs, each key running its own repeat FSM.
module multi_key_decoder #(
  parameter int unsigned           NUM_KEYS      = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES     = {9'h174, 9'h16B, 9'h172, 9'h175},
  parameter bit                    REPEAT_EN     = 1'b1,
  parameter int unsigned           REPEAT_DELAY  = 25_000_000,
  parameter int unsigned           REPEAT_PERIOD = 5_000_000
) (
  input  logic                clk,
  input  logic                resetN,
  multi_key_decoder_if.slave  kbd,
  output logic [NUM_KEYS-1:0] keyIsPressed,
  output logic [NUM_KEYS-1:0] keyRisingEdgePulse,
  output logic [NUM_KEYS-1:0] keyFallingEdgePulse,
  output logic [NUM_KEYS-1:0] keyLatch,
  output logic [NUM_KEYS-1:0] keyRepeatPulse,
  output logic                anyKeyPressed
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DLY_TC = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_TC = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } state_t;

  state_t              r_state    [NUM_KEYS];
  state_t              w_state_nx [NUM_KEYS];
  logic [CNT_W-1:0]    r_cnt      [NUM_KEYS];
  logic [CNT_W-1:0]    w_cnt_nx   [NUM_KEYS];

  logic [NUM_KEYS-1:0] r_pressed;
  logic [NUM_KEYS-1:0] r_pressed_d;
  logic [NUM_KEYS-1:0] r_latch;
  logic [NUM_KEYS-1:0] r_rpt;
  logic [NUM_KEYS-1:0] w_rpt_nx;
  logic [NUM_KEYS-1:0] w_match;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_rel;
  logic [NUM_KEYS-1:0] w_pressed_nx;
  logic [NUM_KEYS-1:0] w_rise;

  // Duplicate codes simply make several indices match the same stream.
  always_comb begin
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      w_match[i] = (kbd.keyCode == KEY_CODES[9*i +: 9]);
    end
  end

  assign w_press      = w_match & {NUM_KEYS{kbd.make}} & ~{NUM_KEYS{kbd.brakee}};
  assign w_rel        = w_match & {NUM_KEYS{kbd.brakee}};
  assign w_pressed_nx = (r_pressed | w_press) & ~w_rel;
  assign w_rise       = r_pressed & ~r_pressed_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pressed   <= '0;
      r_pressed_d <= '0;
      r_latch     <= '0;
      r_rpt       <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_pressed   <= w_pressed_nx;
      r_pressed_d <= r_pressed;
      r_latch     <= r_latch ^ w_rise;
      r_rpt       <= w_rpt_nx;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        r_state[i] <= w_state_nx[i];
        r_cnt[i]   <= w_cnt_nx[i];
      end
    end
  end

  // A release sampled on a terminal-count edge takes priority, so no strobe.
  always_comb begin
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      w_state_nx[i] = r_state[i];
      w_cnt_nx[i]   = r_cnt[i];
      w_rpt_nx[i]   = 1'b0;
      if (!REPEAT_EN || w_rel[i]) begin
        w_state_nx[i] = ST_IDLE;
        w_cnt_nx[i]   = '0;
      end else begin
        case (r_state[i])
          ST_IDLE: begin
            w_cnt_nx[i] = '0;
            if (w_press[i] && !r_pressed[i]) begin
              w_state_nx[i] = ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (r_cnt[i] == DLY_TC) begin
              w_state_nx[i] = ST_REPEAT;
              w_cnt_nx[i]   = '0;
              w_rpt_nx[i]   = 1'b1;
            end else begin
              w_cnt_nx[i] = r_cnt[i] + CNT_ONE;
            end
          end
          ST_REPEAT: begin
            if (r_cnt[i] == PER_TC) begin
              w_cnt_nx[i] = '0;
              w_rpt_nx[i] = 1'b1;
            end else begin
              w_cnt_nx[i] = r_cnt[i] + CNT_ONE;
            end
          end
          default: begin
            w_state_nx[i] = ST_IDLE;
            w_cnt_nx[i]   = '0;
          end
        endcase
      end
    end
  end

  assign keyIsPressed        = r_pressed;
  assign keyRisingEdgePulse  = w_rise;
  assign keyFallingEdgePulse = ~r_pressed & r_pressed_d;
  assign keyLatch            = r_latch;
  assign keyRepeatPulse      = r_rpt;
  assign anyKeyPressed       = |r_pressed;

endmodule
